// File: rtl/fsm_seq_10010_tx_pkg.sv
// Shared constants for the 10010 sync-pattern link: preamble and TX states.
// Optional build macro used by the transmitter: PARITY_EN.
package fsm_seq_10010_tx_pkg;

   localparam logic [4:0] PREAMBLE = 5'b10010;
   localparam int         PRE_LEN  = 5;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_DATA = 3'd2,
      ST_PAR  = 3'd3,
      ST_GAP  = 3'd4
   } tx_state_e;

   // Down-counter width covering the longest state.
   function automatic int cnt_width(input int data_w, input int gap_cyc);
      int m;
      m = PRE_LEN;
      if (data_w + 1 > m) m = data_w + 1;
      if (gap_cyc > m) m = gap_cyc;
      return $clog2(m);
   endfunction

   // Preamble bit for a down-counter value (4 = first bit on the line).
   function automatic logic pre_bit(input logic [2:0] idx);
      logic b;
      case (idx)
         3'd4:    b = PREAMBLE[4];
         3'd3:    b = PREAMBLE[3];
         3'd2:    b = PREAMBLE[2];
         3'd1:    b = PREAMBLE[1];
         3'd0:    b = PREAMBLE[0];
         default: b = 1'b0;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/fsm_seq_10010_tx_shreg.sv
// Parallel-load, MSB-first payload shift register for the 10010 transmitter.
// Load has priority over shift; msb is the bit currently at the head.
module fsm_seq_10010_tx_shreg #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              shift_en,
   input  logic [DATA_W-1:0] load_data,
   output logic              msb
);

   logic [DATA_W-1:0] sh_q;
   logic [DATA_W-1:0] sh_d;

   // Next contents: load a new word or shift toward the MSB.
   always_comb begin
      sh_d = sh_q;
      if (load) begin
         sh_d = load_data;
      end else if (shift_en) begin
         sh_d = sh_q << 1;
      end
   end

   // Shift register storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q <= '0;
      end else begin
         sh_q <= sh_d;
      end
   end

   assign msb = sh_q[DATA_W-1];

endmodule

// File: rtl/fsm_seq_10010_tx.sv
// Serial frame transmitter: preamble 10010, MSB-first payload, zero gap.
// Build macro PARITY_EN appends an even-parity bit after the payload.
module fsm_seq_10010_tx #(
   parameter int DATA_W  = 8,
   parameter int GAP_CYC = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              ser_out,
   output logic              ser_active,
   output logic              tx_done
);

   import fsm_seq_10010_tx_pkg::*;

   localparam int CW = cnt_width(DATA_W, GAP_CYC);

   localparam logic [CW-1:0] CNT_PRE  = CW'(PRE_LEN - 1);
   localparam logic [CW-1:0] CNT_DATA = CW'(DATA_W - 1);
   localparam logic [CW-1:0] CNT_GAP  = CW'(GAP_CYC - 1);

   tx_state_e state_q;
   tx_state_e state_d;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   logic ser_out_q;
   logic ser_out_d;
   logic ser_active_q;
   logic ser_active_d;
   logic tx_done_q;
   logic tx_done_d;
   logic in_ready_q;
   logic in_ready_d;

   logic accept;
   logic cnt_zero;
   logic sh_load;
   logic sh_shift;
   logic sh_msb;

`ifdef PARITY_EN
   logic parity_q;
   logic parity_d;
`endif

   assign accept   = in_valid & in_ready_q;
   assign cnt_zero = (cnt_q == '0);

   fsm_seq_10010_tx_shreg #(
      .DATA_W (DATA_W)
   ) u_shreg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (sh_load),
      .shift_en  (sh_shift),
      .load_data (in_data),
      .msb       (sh_msb)
   );

   // Next state, counter reload and payload load on accept.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_load = 1'b0;
      if (!cnt_zero) begin
         cnt_d = cnt_q - CW'(1);
      end
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_PRE;
               cnt_d   = CNT_PRE;
               sh_load = 1'b1;
            end
         end
         ST_PRE: begin
            if (cnt_zero) begin
               state_d = ST_DATA;
               cnt_d   = CNT_DATA;
            end
         end
         ST_DATA: begin
            if (cnt_zero) begin
`ifdef PARITY_EN
               state_d = ST_PAR;
               cnt_d   = '0;
`else
               state_d = ST_GAP;
               cnt_d   = CNT_GAP;
`endif
            end
         end
`ifdef PARITY_EN
         ST_PAR: begin
            state_d = ST_GAP;
            cnt_d   = CNT_GAP;
         end
`endif
         ST_GAP: begin
            if (cnt_zero) begin
               if (accept) begin
                  state_d = ST_PRE;
                  cnt_d   = CNT_PRE;
                  sh_load = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Registered outputs derived from the state being entered.
   always_comb begin
      ser_out_d    = 1'b0;
      ser_active_d = 1'b0;
      tx_done_d    = 1'b0;
      in_ready_d   = 1'b0;
      sh_shift     = 1'b0;
      case (state_d)
         ST_IDLE: begin
            in_ready_d = 1'b1;
         end
         ST_PRE: begin
            ser_out_d    = pre_bit(cnt_d[2:0]);
            ser_active_d = 1'b1;
         end
         ST_DATA: begin
            ser_out_d    = sh_msb;
            ser_active_d = 1'b1;
            sh_shift     = 1'b1;
         end
`ifdef PARITY_EN
         ST_PAR: begin
            ser_out_d    = parity_q;
            ser_active_d = 1'b1;
         end
`endif
         ST_GAP: begin
            tx_done_d  = (state_q != ST_GAP);
            in_ready_d = (cnt_d == '0);
         end
         default: begin
            in_ready_d = 1'b0;
         end
      endcase
   end

`ifdef PARITY_EN
   // Even parity of the payload, captured with the word.
   always_comb begin
      parity_d = parity_q;
      if (sh_load) begin
         parity_d = ^in_data;
      end
   end

   // Parity bit storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end
`endif

   // State, counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         ser_out_q    <= 1'b0;
         ser_active_q <= 1'b0;
         tx_done_q    <= 1'b0;
         in_ready_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ser_out_q    <= ser_out_d;
         ser_active_q <= ser_active_d;
         tx_done_q    <= tx_done_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign ser_out    = ser_out_q;
   assign ser_active = ser_active_q;
   assign tx_done    = tx_done_q;

endmodule

// File: tb/tb_fsm_seq_10010_tx.sv
// Bench for fsm_seq_10010_tx: frame-list model plus literal timing checks.
// Honours PARITY_EN the same way as the design.
module tb_fsm_seq_10010_tx;

   localparam int DATA_W  = 8;
   localparam int GAP_CYC = 3;
`ifdef PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int FLEN = 5 + DATA_W + PB + GAP_CYC;

   logic              clk      = 1'b0;
   logic              rst_n    = 1'b1;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data  = '0;
   logic              in_ready;
   logic              ser_out;
   logic              ser_active;
   logic              tx_done;

   int checks = 0;
   int errors = 0;

   fsm_seq_10010_tx #(
      .DATA_W  (DATA_W),
      .GAP_CYC (GAP_CYC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .ser_out    (ser_out),
      .ser_active (ser_active),
      .tx_done    (tx_done)
   );

   always #5 clk = ~clk;

   // Model: each accept queues the whole frame as per-cycle entries.
   logic fq_bit[$];
   logic fq_act[$];
   logic fq_done[$];
   logic e_ser  = 1'b0;
   logic e_act  = 1'b0;
   logic e_done = 1'b0;
   logic e_rdy  = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fq_bit.delete();
         fq_act.delete();
         fq_done.delete();
         e_ser  = 1'b0;
         e_act  = 1'b0;
         e_done = 1'b0;
         e_rdy  = 1'b0;
      end else begin
         logic acc;
         acc = in_valid && e_rdy;
         if (fq_bit.size() > 0) begin
            void'(fq_bit.pop_front());
            void'(fq_act.pop_front());
            void'(fq_done.pop_front());
         end
         if (acc) begin
            for (int i = 0; i < 5; i++) begin
               fq_bit.push_back(i == 0 || i == 3);
               fq_act.push_back(1'b1);
               fq_done.push_back(1'b0);
            end
            for (int i = DATA_W - 1; i >= 0; i--) begin
               fq_bit.push_back(in_data[i]);
               fq_act.push_back(1'b1);
               fq_done.push_back(1'b0);
            end
            if (PB == 1) begin
               fq_bit.push_back(^in_data);
               fq_act.push_back(1'b1);
               fq_done.push_back(1'b0);
            end
            for (int i = 0; i < GAP_CYC; i++) begin
               fq_bit.push_back(1'b0);
               fq_act.push_back(1'b0);
               fq_done.push_back(i == 0);
            end
         end
         if (fq_bit.size() > 0) begin
            e_ser  = fq_bit[0];
            e_act  = fq_act[0];
            e_done = fq_done[0];
         end else begin
            e_ser  = 1'b0;
            e_act  = 1'b0;
            e_done = 1'b0;
         end
         e_rdy = (fq_bit.size() <= 1);
      end
   end

   // Per-cycle compare against the model.
   logic chk_en = 1'b0;
   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if (ser_out !== e_ser || ser_active !== e_act ||
             tx_done !== e_done || in_ready !== e_rdy) begin
            errors++;
            $display("FAIL cyc t=%0t: got ser=%b act=%b done=%b rdy=%b expected %b %b %b %b",
                     $time, ser_out, ser_active, tx_done, in_ready,
                     e_ser, e_act, e_done, e_rdy);
         end
      end
   end

   // Event monitor: accept times, detector hits and done pulses.
   int   cyc     = 0;
   int   acc_cyc = 0;
   logic pend    = 1'b0;
   int   accs[$];
   int   hits[$];
   int   dones[$];
   logic [4:0] win = '0;
   logic cap[1:32];
   logic any_out = 1'b0;

   always @(posedge clk) begin
      cyc++;
      if (pend && rst_n) begin
         acc_cyc = cyc;
         accs.push_back(cyc);
      end
   end

   always @(negedge clk) begin
      int rel;
      pend = rst_n && in_valid && in_ready;
      rel  = cyc - acc_cyc + 1;
      win  = {win[3:0], ser_out};
      if (win == 5'b10010) hits.push_back(rel);
      if (tx_done) dones.push_back(rel);
      if (rel >= 1 && rel <= 32) cap[rel] = ser_out;
      if (ser_out || ser_active || tx_done) any_out = 1'b1;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_ev();
      hits.delete();
      dones.delete();
      accs.delete();
   endtask

   function automatic int cap_word(input int first, input int n);
      int v;
      v = 0;
      for (int i = 0; i < n; i++) v = (v << 1) | int'(cap[first + i]);
      return v;
   endfunction

   task automatic send(input logic [DATA_W-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick(1);
      in_valid = 1'b0;
      in_data  = ~d;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      chk_en = 1'b1;
      tick(3);
      chk("reset_outs", {ser_out, ser_active, tx_done, in_ready}, 0);
      rst_n = 1'b1;
      #1;
      chk("ready_before_edge", in_ready, 0);
      tick(1);
      chk("ready_after_edge", in_ready, 1);
      tick(2);

      // Frame of all ones; detector must fire only on the preamble.
      clear_ev();
      send(8'hFF);
      tick(FLEN + 2);
      chk("ff_accepts", accs.size(), 1);
      chk("ff_hits", hits.size(), 1);
      if (hits.size() > 0) chk("ff_hit_cyc", hits[0], 5);
      chk("ff_dones", dones.size(), 1);
      if (dones.size() > 0) chk("ff_done_cyc", dones[0], 14 + PB);
`ifdef PARITY_EN
      chk("ff_line", cap_word(1, 17), 'b10010111111110000);
`else
      chk("ff_line", cap_word(1, 16), 'b1001011111111000);
`endif

      // Payload containing the pattern aliases the detector.
      clear_ev();
      send(8'h12);
      tick(FLEN + 2);
      chk("x12_hits", hits.size(), 2);
      if (hits.size() > 1) begin
         chk("x12_hit0", hits[0], 5);
         chk("x12_hit1", hits[1], 13);
      end

      // Held valid: second accept at the minimum spacing.
      clear_ev();
      in_valid = 1'b1;
      in_data  = 8'hFF;
      for (int i = 0; i < 40; i++) begin
         if (accs.size() == 1) in_data = 8'h80;
         if (accs.size() >= 2) break;
         tick(1);
      end
      in_valid = 1'b0;
      chk("b2b_accepts", accs.size(), 2);
      if (accs.size() >= 2) chk("b2b_spacing", accs[1] - accs[0], FLEN);
      tick(FLEN + 2);
      chk("b2b_dones", dones.size(), 2);

      // Long idle: line stays quiet.
      clear_ev();
      any_out = 1'b0;
      tick(50);
      chk("idle_quiet", any_out, 0);
      chk("idle_hits", hits.size(), 0);

      // Reset during payload bit 3 (frame cycle 10).
      clear_ev();
      send(8'hA5);
      tick(9);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_async_outs", {ser_out, ser_active, in_ready}, 0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      chk("rst_ready", in_ready, 1);
      tick(FLEN);
      chk("rst_no_done", dones.size(), 0);
      clear_ev();
      send(8'hFF);
      tick(FLEN + 2);
      chk("post_rst_done", dones.size(), 1);
      if (dones.size() > 0) chk("post_rst_done_cyc", dones[0], 14 + PB);
      chk("post_rst_line", cap_word(1, 13), 'b1001011111111);

`ifdef PARITY_EN
      clear_ev();
      send(8'h07);
      tick(FLEN + 2);
      chk("par07_bit", int'(cap[14]), 1);
      if (dones.size() > 0) chk("par07_done", dones[0], 15);
      clear_ev();
      send(8'h03);
      tick(FLEN + 2);
      chk("par03_bit", int'(cap[14]), 0);
`endif

      tick(2);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
